alu_trace_capture: RTL and testbench

- Hardware writer for ALU execute traces: snoops ALU transactions (ALUctr, opA, opB, result) and buffers them in a record FIFO.
- Serialises each record into 32-bit words over a valid/ready stream for host dump or post-silicon comparison against the execute-trace vector format.
- Sits beside the ALU in the execute stage, observe-only; never stalls the ALU.

---
 rtl/alu_trace_capture.sv | 159 +++++++++++++++
 tb/tb_alu_trace_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_trace_capture.sv
// ALU execute-trace writer: snoops ALU transactions into a record FIFO and
// serialises each record as 32-bit words on a valid/ready stream.
// Optional macro ALU_TRACE_TIMESTAMP_EN appends a cycle-count word W4.
module alu_trace_capture #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_valid,
  input  logic [3:0]               cap_ctrl,
  input  logic [31:0]              cap_a,
  input  logic [31:0]              cap_b,
  input  logic [31:0]              cap_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_W0   = 3'd1;
  localparam logic [2:0] ST_W1   = 3'd2;
  localparam logic [2:0] ST_W2   = 3'd3;
  localparam logic [2:0] ST_W3   = 3'd4;
`ifdef ALU_TRACE_TIMESTAMP_EN
  localparam logic [2:0] ST_W4   = 3'd5;
  localparam logic [2:0] ST_LAST = ST_W4;
`else
  localparam logic [2:0] ST_LAST = ST_W3;
`endif

  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
`ifdef ALU_TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } rec_t;

  logic [15:0]   seq;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  rec_t          mem [DEPTH];
  rec_t          cap_rec;
  rec_t          hold;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          push;
  logic          pop;
  logic          accept;
  logic          at_last;

`ifdef ALU_TRACE_TIMESTAMP_EN
  logic [31:0]   cycle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  // NOTE: every field gets a value on every pass, so no latch can be inferred.
  always_comb begin
    cap_rec        = '0;
    cap_rec.w0     = {seq, 10'b0, cap_result[31], (cap_result == 32'd0), cap_ctrl};
    cap_rec.a      = cap_a;
    cap_rec.b      = cap_b;
    cap_rec.result = cap_result;
`ifdef ALU_TRACE_TIMESTAMP_EN
    cap_rec.ts     = cycle_cnt;
`endif
  end

  // Admission uses the registered level only: a same-cycle pop never frees room.
  assign accept    = out_valid && out_ready;
  assign at_last   = (state == ST_LAST);
  assign push      = cap_valid && (fifo_level < LVL_FULL);
  assign pop       = (fifo_level != '0) && ((state == ST_IDLE) || (accept && at_last));
  assign state_nxt = state + 3'd1;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq        <= '0;
      drop_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (cap_valid) seq <= seq + 16'd1;
      if (cap_valid && !push && (drop_cnt != {DROP_W{1'b1}}))
        drop_cnt <= drop_cnt + DROP_W'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // NOTE: the record storage is not reset; the pointers and level alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap_rec;
  end

  function automatic logic [31:0] word_sel(input logic [2:0] st, input rec_t r);
    case (st)
      ST_W1:   word_sel = r.a;
      ST_W2:   word_sel = r.b;
      ST_W3:   word_sel = r.result;
`ifdef ALU_TRACE_TIMESTAMP_EN
      ST_W4:   word_sel = r.ts;
`endif
      default: word_sel = r.w0;
    endcase
  endfunction

  // Serializer: outputs are registered and advance only on acceptance, and the
  // next record is loaded on the same edge the last word goes out (no bubble).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (pop) begin
      hold      <= mem[rd_ptr];
      state     <= ST_W0;
      out_valid <= 1'b1;
      out_data  <= mem[rd_ptr].w0;
      out_last  <= 1'b0;
    end else if (accept) begin
      if (at_last) begin
        state     <= ST_IDLE;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
      end else begin
        state    <= state_nxt;
        out_data <= word_sel(state_nxt, hold);
        out_last <= (state_nxt == ST_LAST);
      end
    end
  end

endmodule

// File: tb/tb_alu_trace_capture.sv
// Directed, table-driven bench for alu_trace_capture: single records, flags,
// backpressure, overflow, full-with-pop and reset mid-record.
module tb_alu_trace_capture;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;
`ifdef ALU_TRACE_TIMESTAMP_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cap_valid;
  logic [3:0]             cap_ctrl;
  logic [31:0]            cap_a;
  logic [31:0]            cap_b;
  logic [31:0]            cap_result;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;
  logic                   out_last;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [DROP_W-1:0]      drop_cnt;

  alu_trace_capture #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cap_valid  (cap_valid),
    .cap_ctrl   (cap_ctrl),
    .cap_a      (cap_a),
    .cap_b      (cap_b),
    .cap_result (cap_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] w0;
  } vec_t;

  vec_t vecs [5];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Called at a negedge with out_ready=1: takes the presented word, then moves
  // to the negedge after it has been accepted.
  task automatic get_word(output logic [31:0] d, output logic l, output int waited);
    d = '0;
    l = 1'b0;
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (out_valid) begin
      d = out_data;
      l = out_last;
    end else begin
      checks++;
      errors++;
      $display("FAIL get_word_timeout: out_valid still 0 after %0d cycles", waited);
    end
    @(negedge clk);
  endtask

  task automatic set_cap(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r);
    cap_valid  = 1'b1;
    cap_ctrl   = ctrl;
    cap_a      = a;
    cap_b      = b;
    cap_result = r;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cap_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Capture one record into an idle block and check latency and every word.
  task automatic run_vector(input vec_t v, input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    logic        l;
    int          w;
    out_ready = 1'b1;
    set_cap(v.ctrl, v.a, v.b, v.r);
    @(negedge clk);
    cap_valid = 1'b0;
    check($sformatf("%s_lat_pre", tag), out_valid, 1'b0);
    @(negedge clk);
    check($sformatf("%s_lat_w0", tag), out_valid, 1'b1);
    for (int k = 0; k < NW; k++) begin
      get_word(d, l, w);
      exp = (k == 0) ? v.w0 : (k == 1) ? v.a : (k == 2) ? v.b : v.r;
      if (k < 4) check($sformatf("%s_w%0d", tag, k), d, exp);
      check($sformatf("%s_last%0d", tag, k), l, (k == NW - 1));
    end
    check($sformatf("%s_idle", tag), out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        l;
    int          w;
    vec_t        gap_v;
    vec_t        post_v;

    vecs[0] = '{4'h2, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 32'h0000_0002};
    vecs[1] = '{4'h6, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 32'h0001_0016};
    vecs[2] = '{4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0002_0022};
    vecs[3] = '{4'h4, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0003_0024};
    vecs[4] = '{4'h0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 32'h0004_0010};
    gap_v   = '{4'h2, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 32'h000B_0002};
    post_v  = '{4'h3, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 32'h0000_0023};

    cap_ctrl = '0; cap_a = '0; cap_b = '0; cap_result = '0;
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    // Single records, flags and sequence numbering.
    for (int i = 0; i < 5; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Backpressure held for 5 cycles while W2 is presented.
    set_cap(4'h1, 32'h1234_0000, 32'h0000_FFFF, 32'h1234_FFFF);
    @(negedge clk);
    cap_valid = 1'b0;
    @(negedge clk);
    get_word(d, l, w);
    check("bp_w0", d, 32'h0005_0001);
    get_word(d, l, w);
    check("bp_w1", d, 32'h1234_0000);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1'b1);
      check($sformatf("bp_hold_data%0d", i), out_data, 32'h0000_FFFF);
      check($sformatf("bp_hold_last%0d", i), out_last, 1'b0);
    end
    out_ready = 1'b1;
    get_word(d, l, w);
    check("bp_w2", d, 32'h0000_FFFF);
    check("bp_w2_nowait", w, 0);
    get_word(d, l, w);
    check("bp_w3", d, 32'h1234_FFFF);
    check("bp_w3_last", l, (NW == 4));
    for (int k = 4; k < NW; k++) begin
      get_word(d, l, w);
      check("bp_w4_last", l, 1'b1);
    end
    check("bp_idle", out_valid, 1'b0);

    // Overflow: 11 offers against a stalled sink.
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_cap(4'h2, i, 32'h0, i + 1);
      @(negedge clk);
    end
    cap_valid = 1'b0;
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_drop", drop_cnt, 2);
    out_ready = 1'b1;
    for (int r = 0; r <= DEPTH; r++) begin
      for (int k = 0; k < NW; k++) begin
        get_word(d, l, w);
        if (k == 0) begin
          check($sformatf("ovf_seq%0d", r), d[31:16], r);
          if (r > 0) check($sformatf("ovf_nobubble%0d", r), w, 0);
        end
        if (k == 1) check($sformatf("ovf_a%0d", r), d, r);
      end
    end
    check("ovf_drained_valid", out_valid, 1'b0);
    check("ovf_drained_level", fifo_level, 0);
    run_vector(gap_v, "gap");

    // Full FIFO while the last word is accepted and a new record is offered.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_cap(4'h0, i, 32'h0, i + 1);
      @(negedge clk);
    end
    cap_valid = 1'b0;
    check("fp_level_full", fifo_level, DEPTH);
    check("fp_w0_seq0", out_data, 32'h0000_0000);
    out_ready = 1'b1;
    for (int k = 0; k < NW - 1; k++) get_word(d, l, w);
    check("fp_at_last", out_last, 1'b1);
    set_cap(4'h5, 32'hDEAD_BEEF, 32'h0, 32'h1);
    @(negedge clk);
    cap_valid = 1'b0;
    check("fp_drop", drop_cnt, 1);
    check("fp_level", fifo_level, DEPTH - 1);
    check("fp_next_valid", out_valid, 1'b1);
    check("fp_next_seq", out_data[31:16], 1);

    // Reset during W2 with 3 records buffered.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_cap(4'h2, 32'h100 + i, 32'h200 + i, 32'h300 + i);
      @(negedge clk);
    end
    cap_valid = 1'b0;
    check("rm_level", fifo_level, 3);
    out_ready = 1'b1;
    get_word(d, l, w);
    get_word(d, l, w);
    check("rm_at_w2", out_data, 32'h0000_0200);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rm_valid", out_valid, 1'b0);
    check("rm_level0", fifo_level, 0);
    check("rm_drop0", drop_cnt, 0);
    check("rm_last0", out_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_vector(post_v, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
